// File: rtl/lbist_controller_if.sv
// Handshake bundle between the test access logic, the LBIST sequencer and the
// LFSR/MISR datapath strobes.
interface lbist_controller_if #(
    parameter int SIG_W        = 32,
    parameter int NUM_PATTERNS = 1000
);
    localparam int PAT_W = $clog2(NUM_PATTERNS + 1);

    logic             start;
    logic             abort;
    logic [SIG_W-1:0] misr_sig;
    logic             lfsr_reset;
    logic             lfsr_en;
    logic             capture_en;
    logic             misr_reset;
    logic             misr_en;
    logic             test_mode;
    logic             busy;
    logic [PAT_W-1:0] pat_count;
    logic             done;
    logic             pass;

    // Test access / datapath side.
    modport master (
        output start, abort, misr_sig,
        input  lfsr_reset, lfsr_en, capture_en, misr_reset, misr_en,
        input  test_mode, busy, pat_count, done, pass
    );

    // Sequencer side.
    modport slave (
        input  start, abort, misr_sig,
        output lfsr_reset, lfsr_en, capture_en, misr_reset, misr_en,
        output test_mode, busy, pat_count, done, pass
    );
endinterface

// File: rtl/lbist_controller.sv
// LBIST session sequencer: seeds the LFSR, runs NUM_PATTERNS shift/capture
// loops, lets the MISR settle, then compares the signature against GOLDEN.
module lbist_controller #(
    parameter int               NUM_PATTERNS = 1000,
    parameter int               SHIFT_LEN    = 286,
    parameter int               MISR_LAT     = 2,
    parameter int               SIG_W        = 32,
    parameter logic [SIG_W-1:0] GOLDEN       = '0
) (
    input  logic                clk,
    input  logic                reset,
    lbist_controller_if.slave   if_bist
);
    localparam int PAT_W   = $clog2(NUM_PATTERNS + 1);
    localparam int SHIFT_W = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
    localparam int DRAIN_W = (MISR_LAT > 1) ? $clog2(MISR_LAT) : 1;

    localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(SHIFT_LEN - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MISR_LAT - 1);
    localparam logic [PAT_W-1:0]   PAT_LAST   = PAT_W'(NUM_PATTERNS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_SHIFT   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_COMPARE = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]         r_state;
    logic [SHIFT_W-1:0] r_shift_cnt;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [PAT_W-1:0]   r_pat_count;
    logic               r_pass;
    logic               r_done;
    logic               r_lfsr_reset;
    logic               r_lfsr_en;
    logic               r_capture_en;
    logic               r_misr_reset;
    logic               r_misr_en;
    logic               r_active;

    logic [2:0]         w_state_nxt;
    logic [PAT_W-1:0]   w_pat_inc;
    logic               w_active_nxt;

    assign w_pat_inc = r_pat_count + PAT_W'(1);

    always_comb begin
        // NOTE: default first so every path assigns w_state_nxt; otherwise a latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (if_bist.start) w_state_nxt = S_INIT;
            S_INIT:    w_state_nxt = S_SHIFT;
            S_SHIFT:   if (r_shift_cnt == SHIFT_LAST) w_state_nxt = S_CAPTURE;
            S_CAPTURE: begin
                if (w_pat_inc == PAT_LAST)
                    w_state_nxt = (MISR_LAT == 0) ? S_COMPARE : S_DRAIN;
                else
                    w_state_nxt = S_SHIFT;
            end
            S_DRAIN:   if (r_drain_cnt == DRAIN_LAST) w_state_nxt = S_COMPARE;
            S_COMPARE: w_state_nxt = S_DONE;
            S_DONE:    if (if_bist.start) w_state_nxt = S_INIT;
            default:   w_state_nxt = S_IDLE;
        endcase
        // abort outranks start in every state; in IDLE it simply holds IDLE.
        if (if_bist.abort) w_state_nxt = S_IDLE;
    end

    assign w_active_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shift_cnt <= '0;
            r_drain_cnt <= '0;
            r_pat_count <= '0;
            r_pass      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_SHIFT && w_state_nxt == S_SHIFT)
                r_shift_cnt <= r_shift_cnt + SHIFT_W'(1);
            else
                r_shift_cnt <= '0;

            if (r_state == S_DRAIN && w_state_nxt == S_DRAIN)
                r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
            else
                r_drain_cnt <= '0;

            if (w_state_nxt == S_IDLE || w_state_nxt == S_INIT)
                r_pat_count <= '0;
            else if (r_state == S_CAPTURE)
                r_pat_count <= w_pat_inc;

            if (r_state == S_COMPARE && w_state_nxt == S_DONE)
                r_pass <= (if_bist.misr_sig == GOLDEN);
            else if (w_state_nxt != S_DONE)
                r_pass <= 1'b0;
        end
    end

    // Strobes are registered from the next state so the datapath sees glitch-free levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr_reset <= 1'b0;
            r_lfsr_en    <= 1'b0;
            r_capture_en <= 1'b0;
            r_misr_reset <= 1'b0;
            r_misr_en    <= 1'b0;
            r_active     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_lfsr_reset <= (w_state_nxt == S_INIT);
            r_lfsr_en    <= (w_state_nxt == S_SHIFT);
            r_capture_en <= (w_state_nxt == S_CAPTURE);
            r_misr_reset <= (w_state_nxt == S_INIT);
            r_misr_en    <= (w_state_nxt == S_CAPTURE);
            r_active     <= w_active_nxt;
            r_done       <= (w_state_nxt == S_DONE);
        end
    end

    assign if_bist.lfsr_reset = r_lfsr_reset;
    assign if_bist.lfsr_en    = r_lfsr_en;
    assign if_bist.capture_en = r_capture_en;
    assign if_bist.misr_reset = r_misr_reset;
    assign if_bist.misr_en    = r_misr_en;
    assign if_bist.test_mode  = r_active;
    assign if_bist.busy       = r_active;
    assign if_bist.pat_count  = r_pat_count;
    assign if_bist.done       = r_done;
    assign if_bist.pass       = r_pass;

    a_strobe_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0({r_lfsr_en, r_capture_en, r_lfsr_reset}));

endmodule

// File: tb/tb_lbist_controller.sv
// Directed bench for lbist_controller: a 4x3 session with MISR_LAT=2 and a
// minimal 1x1 session with MISR_LAT=0, both sharing clk and reset.
module tb_lbist_controller;
    localparam logic [31:0] GOLD_A = 32'hC0DE_1234;
    localparam int          BUDGET = 100;

    localparam logic [8:0] V_INIT    = 9'b100101100;
    localparam logic [8:0] V_SHIFT   = 9'b010001100;
    localparam logic [8:0] V_CAPTURE = 9'b001011100;
    localparam logic [8:0] V_COMPARE = 9'b000001100;
    localparam logic [8:0] V_DONE_P  = 9'b000000011;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    lbist_controller_if #(.SIG_W(32), .NUM_PATTERNS(4)) bus_a ();
    lbist_controller_if #(.SIG_W(32), .NUM_PATTERNS(1)) bus_m ();

    lbist_controller #(
        .NUM_PATTERNS(4), .SHIFT_LEN(3), .MISR_LAT(2), .SIG_W(32), .GOLDEN(GOLD_A)
    ) u_dut (.clk(clk), .reset(reset), .if_bist(bus_a.slave));

    lbist_controller #(
        .NUM_PATTERNS(1), .SHIFT_LEN(1), .MISR_LAT(0), .SIG_W(32), .GOLDEN(32'h0)
    ) u_min (.clk(clk), .reset(reset), .if_bist(bus_m.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {lfsr_reset, lfsr_en, capture_en, misr_reset, misr_en, test_mode, busy, done, pass}
    function automatic logic [8:0] outs_a();
        return {bus_a.lfsr_reset, bus_a.lfsr_en, bus_a.capture_en, bus_a.misr_reset,
                bus_a.misr_en, bus_a.test_mode, bus_a.busy, bus_a.done, bus_a.pass};
    endfunction

    function automatic logic [8:0] outs_m();
        return {bus_m.lfsr_reset, bus_m.lfsr_en, bus_m.capture_en, bus_m.misr_reset,
                bus_m.misr_en, bus_m.test_mode, bus_m.busy, bus_m.done, bus_m.pass};
    endfunction

    // Caller raises bus_a.start at a negedge; the next posedge samples it.
    task automatic run_a(input bit pulse, output int cycles, output int n_lr,
                         output int n_le, output int n_burst, output int n_cap,
                         output int n_men, output int n_excl, output logic [8:0] first);
        bit prev_le;
        @(negedge clk);
        if (pulse) bus_a.start = 1'b0;
        first   = outs_a();
        cycles  = 0; n_lr = 0; n_le = 0; n_burst = 0;
        n_cap   = 0; n_men = 0; n_excl = 0; prev_le = 1'b0;
        while (bus_a.done !== 1'b1 && cycles < BUDGET) begin
            if (bus_a.lfsr_reset) n_lr++;
            if (bus_a.lfsr_en) n_le++;
            if (bus_a.lfsr_en && !prev_le) n_burst++;
            if (bus_a.capture_en) n_cap++;
            if (bus_a.misr_en) n_men++;
            if (int'(bus_a.lfsr_en) + int'(bus_a.capture_en) + int'(bus_a.lfsr_reset) > 1) n_excl++;
            prev_le = bus_a.lfsr_en;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (outs_a() !== 9'b0 || bus_a.pat_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_a: outs=%b pat=%0d, want outs=000000000 pat=0", outs_a(), bus_a.pat_count);
        end
        checks++;
        if (outs_m() !== 9'b0 || bus_m.pat_count !== 1'd0) begin
            failures++;
            $display("FAIL reset_m: outs=%b pat=%0d, want outs=000000000 pat=0", outs_m(), bus_m.pat_count);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (outs_a() !== 9'b0) begin
            failures++;
            $display("FAIL idle_after_reset: outs=%b, want 000000000", outs_a());
        end
    endtask

    task automatic test_nominal_pass();
        int cyc, lr, le, bu, cap, men, ex;
        logic [8:0] first;
        bus_a.misr_sig = GOLD_A;
        bus_a.start    = 1'b1;
        run_a(1'b1, cyc, lr, le, bu, cap, men, ex, first);
        checks++;
        if (first !== V_INIT) begin
            failures++;
            $display("FAIL nom_init: outs=%b, want %b", first, V_INIT);
        end
        checks++;
        if (cyc !== 20) begin
            failures++;
            $display("FAIL nom_latency: done after %0d cycles, want 20", cyc);
        end
        checks++;
        if (lr !== 1 || le !== 12 || bu !== 4) begin
            failures++;
            $display("FAIL nom_shift: lfsr_reset=%0d lfsr_en=%0d bursts=%0d, want 1 12 4", lr, le, bu);
        end
        checks++;
        if (cap !== 4 || men !== 4 || ex !== 0) begin
            failures++;
            $display("FAIL nom_capture: capture=%0d misr_en=%0d overlap=%0d, want 4 4 0", cap, men, ex);
        end
        checks++;
        if (outs_a() !== V_DONE_P || bus_a.pat_count !== 3'd4) begin
            failures++;
            $display("FAIL nom_done: outs=%b pat=%0d, want %b pat=4", outs_a(), bus_a.pat_count, V_DONE_P);
        end
        @(negedge clk);
        checks++;
        if (outs_a() !== V_DONE_P || bus_a.pat_count !== 3'd4) begin
            failures++;
            $display("FAIL nom_hold: outs=%b pat=%0d, want %b pat=4", outs_a(), bus_a.pat_count, V_DONE_P);
        end
    endtask

    task automatic test_fail_signature();
        int cyc, lr, le, bu, cap, men, ex;
        logic [8:0] first;
        bus_a.misr_sig = GOLD_A ^ 32'h1;
        bus_a.start    = 1'b1;
        run_a(1'b1, cyc, lr, le, bu, cap, men, ex, first);
        checks++;
        if (cyc !== 20 || bus_a.done !== 1'b1 || bus_a.pass !== 1'b0) begin
            failures++;
            $display("FAIL sig_mismatch: cycles=%0d done=%b pass=%b, want 20 1 0", cyc, bus_a.done, bus_a.pass);
        end
    endtask

    task automatic test_abort();
        int cyc, lr, le, bu, cap, men, ex;
        logic [8:0] first;
        bus_a.misr_sig = GOLD_A;
        bus_a.start    = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (bus_a.lfsr_en !== 1'b1 || bus_a.pat_count !== 3'd1) begin
            failures++;
            $display("FAIL abort_setup: lfsr_en=%b pat=%0d, want 1 1", bus_a.lfsr_en, bus_a.pat_count);
        end
        bus_a.abort = 1'b1;
        @(negedge clk);
        bus_a.abort = 1'b0;
        checks++;
        if (outs_a() !== 9'b0 || bus_a.pat_count !== 3'd0) begin
            failures++;
            $display("FAIL abort_idle: outs=%b pat=%0d, want 000000000 pat=0", outs_a(), bus_a.pat_count);
        end
        @(negedge clk);
        bus_a.start = 1'b1;
        run_a(1'b1, cyc, lr, le, bu, cap, men, ex, first);
        checks++;
        if (cyc !== 20 || bus_a.pass !== 1'b1 || bus_a.pat_count !== 3'd4) begin
            failures++;
            $display("FAIL abort_rerun: cycles=%0d pass=%b pat=%0d, want 20 1 4", cyc, bus_a.pass, bus_a.pat_count);
        end
    endtask

    task automatic test_minimal();
        logic [8:0] exp_seq [5];
        exp_seq = '{V_INIT, V_SHIFT, V_CAPTURE, V_COMPARE, V_DONE_P};
        bus_m.misr_sig = 32'h0;
        bus_m.start    = 1'b1;
        @(negedge clk);
        bus_m.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (outs_m() !== exp_seq[k]) begin
                failures++;
                $display("FAIL min_seq[%0d]: outs=%b, want %b", k, outs_m(), exp_seq[k]);
            end
            if (k < 4) @(negedge clk);
        end
        checks++;
        if (bus_m.pat_count !== 1'd1) begin
            failures++;
            $display("FAIL min_pat: pat=%0d, want 1", bus_m.pat_count);
        end
    endtask

    task automatic test_async_reset();
        int busy_seen;
        bus_a.misr_sig = GOLD_A;
        bus_a.start    = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (outs_a() !== V_CAPTURE) begin
            failures++;
            $display("FAIL areset_setup: outs=%b, want %b", outs_a(), V_CAPTURE);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (outs_a() !== 9'b0 || bus_a.pat_count !== 3'd0) begin
            failures++;
            $display("FAIL areset_immediate: outs=%b pat=%0d, want 000000000 pat=0", outs_a(), bus_a.pat_count);
        end
        @(negedge clk);
        reset     = 1'b0;
        busy_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus_a.busy !== 1'b0) busy_seen++;
        end
        checks++;
        if (busy_seen !== 0) begin
            failures++;
            $display("FAIL areset_idle: busy high in %0d cycles, want 0", busy_seen);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, lr, le, bu, cap, men, ex;
        logic [8:0] first;
        logic [31:0] sigs [3];
        logic        want [3];
        sigs = '{GOLD_A, GOLD_A ^ 32'h4, GOLD_A};
        want = '{1'b1, 1'b0, 1'b1};
        bus_a.start = 1'b1;
        for (int s = 0; s < 3; s++) begin
            bus_a.misr_sig = sigs[s];
            run_a(1'b0, cyc, lr, le, bu, cap, men, ex, first);
            checks++;
            if (first !== V_INIT || lr !== 1 || cyc !== 20 || bus_a.pass !== want[s]) begin
                failures++;
                $display("FAIL b2b[%0d]: init=%b lfsr_reset=%0d cycles=%0d pass=%b, want %b 1 20 %b",
                         s, first, lr, cyc, bus_a.pass, V_INIT, want[s]);
            end
        end
        bus_a.start = 1'b0;
        @(negedge clk);
        checks++;
        if (outs_a() !== V_DONE_P) begin
            failures++;
            $display("FAIL b2b_stop: outs=%b, want %b", outs_a(), V_DONE_P);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        bus_a.start    = 1'b0;
        bus_a.abort    = 1'b0;
        bus_a.misr_sig = '0;
        bus_m.start    = 1'b0;
        bus_m.abort    = 1'b0;
        bus_m.misr_sig = '0;
        test_reset();
        test_nominal_pass();
        test_fail_signature();
        test_abort();
        test_minimal();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lbist_controller.md
Name: lbist_controller

Overview:
- Sequences one LBIST session around the pattern-generator LFSR, the scan chains and the signature MISR.
- Session order: reset the LFSR to its seed, then loop NUM_PATTERNS times through shift (LFSR advancing) and capture.
- After the last pattern, waits for the MISR to settle, compares its signature to a golden value, then reports done and pass.
- Sits between the top-level test access logic (start, abort) and the LFSR/MISR datapath (reset and enable strobes).

Parameters:
- NUM_PATTERNS, 1000: patterns per session; legal range >= 1.
- SHIFT_LEN, 286: shift cycles per pattern, i.e. cycles lfsr_en is held high; legal range >= 1.
- MISR_LAT, 2: settle cycles between the last capture and the compare; legal range >= 0.
- SIG_W, 32: MISR signature width.
- GOLDEN, 32'h0: expected signature. Width is SIG_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled in IDLE or DONE to begin a session.
- abort  in  1  level; terminates any session in progress.
- misr_sig  in  SIG_W  current MISR signature.
- lfsr_reset  out  1  drives the LFSR reset (reloads SEED).
- lfsr_en  out  1  LFSR advance / scan shift enable.
- capture_en  out  1  scan capture strobe.
- misr_reset  out  1  clears the MISR.
- misr_en  out  1  MISR compaction enable.
- test_mode  out  1  high while a session is active.
- busy  out  1  high in every state except IDLE and DONE.
- pat_count  out  clog2(NUM_PATTERNS+1)  number of completed captures.
- done  out  1  session finished.
- pass  out  1  signature matched; valid only while done=1.

Behaviour:
- Every output is a registered function of state and counters (Moore); no combinational path from input to output.
- Reset, asynchronous: state=IDLE; shift_cnt=0; pat_count=0; every output 0.
- IDLE: start=1 moves to INIT on the next edge. All outputs stay 0.
- INIT, 1 cycle:
  - lfsr_reset=1, misr_reset=1, test_mode=1, busy=1.
  - pat_count and shift_cnt are cleared to 0.
  - Next state is SHIFT.
- SHIFT, SHIFT_LEN cycles:
  - lfsr_en=1; shift_cnt counts 0..SHIFT_LEN-1.
  - When shift_cnt=SHIFT_LEN-1, next state is CAPTURE and shift_cnt returns to 0.
- CAPTURE, 1 cycle:
  - capture_en=1, misr_en=1; pat_count increments at the end of the cycle.
  - If the incremented pat_count equals NUM_PATTERNS, next state is DRAIN (or COMPARE directly when MISR_LAT=0); otherwise SHIFT.
- DRAIN, MISR_LAT cycles: all strobes 0, test_mode=1; then COMPARE.
- COMPARE, 1 cycle: pass is registered as (misr_sig == GOLDEN); next state is DONE.
- DONE:
  - done=1; pass is held; test_mode=0; busy=0; pat_count holds NUM_PATTERNS.
  - start=1 moves to INIT, and done and pass clear on that transition.
  - If start is still high when DONE is first entered, a new session starts on the next edge (level-sensitive by design).
- Strobe exclusivity: at most one of lfsr_en, capture_en or lfsr_reset is high in any cycle.
- abort:
  - abort=1 in any state other than IDLE forces IDLE on the next edge.
  - All outputs go to 0, including done and pass; pat_count clears.
  - abort beats start when both are high in the same cycle.
  - abort in IDLE has no effect.
- Counter widths: each counter is sized to hold its maximum value without overflow. pat_count never wraps.
- Reset asserted mid-session: immediate return to IDLE with all outputs 0. No partial status is kept.
- Session length: from the edge that samples start, done rises 1 + NUM_PATTERNS*(SHIFT_LEN+1) + MISR_LAT + 1 cycles later.

Test Plan:
- Nominal pass (NUM_PATTERNS=4, SHIFT_LEN=3, MISR_LAT=2, misr_sig tied to GOLDEN), pulse start:
  - lfsr_reset pulses exactly once.
  - lfsr_en is high for 12 cycles in 4 bursts of 3.
  - capture_en and misr_en each pulse 4 times.
  - done rises 20 cycles after start is sampled, with pass=1 and pat_count=4.
- Fail: same configuration with misr_sig = GOLDEN^1 -> done=1, pass=0 at the same cycle.
- Abort during pattern 2 of the SHIFT phase -> next cycle: IDLE, all outputs 0, pat_count=0.
  - A later start runs a complete 20-cycle session.
- Minimal configuration (NUM_PATTERNS=1, SHIFT_LEN=1, MISR_LAT=0) -> sequence INIT, SHIFT, CAPTURE, COMPARE, DONE.
  - done rises 4 cycles after start is sampled.
- Asynchronous reset asserted mid-CAPTURE, between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
  - After reset is released, busy stays 0 until start.
- Restart from DONE with start held high -> done and pass clear on entry to INIT.
  - Sessions repeat back-to-back, lfsr_reset pulses once per session, and pass tracks misr_sig each time.
